// File: rtl/usr_sequencer_if.sv
// Command and response handshake bundle between the host-side glue and the
// shift-register sequencer.
interface usr_sequencer_if #(
    parameter int BITS = 8,
    parameter int CW   = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [BITS-1:0] cmd_data;
    logic [CW-1:0]   cmd_count;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BITS-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/usr_sequencer.sv
// Command-driven controller for the universal shift register: runs load, shift
// and serial-stream commands, holds the register in between, returns the result.
module usr_sequencer #(
    parameter int BITS = 8,
    parameter int CW   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    usr_sequencer_if.slave  bus,
    input  logic [BITS-1:0] sr_q,
    output logic [1:0]      sr_ctrl,
    output logic [BITS-1:0] sr_data,
    output logic            busy
);
    localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [1:0]      op_r;
    logic [BITS-1:0] data_r;
    logic [CW-1:0]   rem_r;
    logic [IW-1:0]   idx_r;
    logic            cmd_ready_r;
    logic            busy_r;
    logic            rsp_valid_r;
    logic [BITS-1:0] rsp_data_r;

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign busy          = busy_r;

    // Command FSM; handshake flags are updated together with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            op_r        <= 2'b00;
            data_r      <= {BITS{1'b0}};
            rem_r       <= {CW{1'b0}};
            idx_r       <= {IW{1'b0}};
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {BITS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_r        <= bus.cmd_op;
                        data_r      <= bus.cmd_data;
                        rem_r       <= bus.cmd_count;
                        idx_r       <= {IW{1'b0}};
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (bus.cmd_op == 2'd0) begin
                            state_r <= ST_LOAD;
                        end else if (bus.cmd_count != {CW{1'b0}}) begin
                            state_r <= ST_SHIFT;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_DONE;
                end
                ST_SHIFT: begin
                    rem_r <= rem_r - CW'(1);
                    // Serial source index wraps so long streams replay the data word.
                    if (idx_r == IW'(BITS - 1)) begin
                        idx_r <= {IW{1'b0}};
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                    if (rem_r == CW'(1)) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle sees the register after the last applied op.
                    if (!rsp_valid_r) begin
                        rsp_data_r  <= sr_q;
                        rsp_valid_r <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Register drive decode; idle, done and reset reload the register's own value.
    always_comb begin
        sr_ctrl = 2'b00;
        sr_data = sr_q;
        case (state_r)
            ST_LOAD: begin
                sr_ctrl = 2'b00;
                sr_data = data_r;
            end
            ST_SHIFT: begin
                case (op_r)
                    2'd1: sr_ctrl = 2'b10;
                    2'd2: sr_ctrl = 2'b01;
                    2'd3: begin
                        sr_ctrl = 2'b11;
                        sr_data = {sr_q[BITS-1:1], data_r[idx_r]};
                    end
                    default: sr_ctrl = 2'b00;
                endcase
            end
            default: begin
                sr_ctrl = 2'b00;
                sr_data = sr_q;
            end
        endcase
    end
endmodule
